keymgr_sideload_ctrl: RTL
=========================

Name: keymgr_sideload_ctrl

Overview:
- Sequences a hardware key from the key manager into a consumer's sideload register file, one 32-bit word per handshake.
- Captures the two-share 256-bit key when `keymgr_key_i.valid` rises, then streams the words share-major to the consumer.
- Signals `key_valid_o` once all words are loaded.
- When `valid` drops, wipes every consumer word to zero.
- Sits between the key manager interface and crypto-block key registers (e.g. AES/KMAC sideload).

Parameters:
- NumSharesKey, 2, number of key shares; must match `keymgr_pkg` key array depth.
- NumRegsKey, 8, 32-bit words per share (NumRegsKey*32 = 256).
- ShareIdxW, $clog2(NumSharesKey) (min 1), share index width; derived, not overridable.
- RegIdxW, $clog2(NumRegsKey), word index width; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- keymgr_key_i  in  keymgr_pkg::hw_key_req_t (513)  valid flag plus key[1:0][255:0].
- wr_valid_o  out  1  write beat valid.
- wr_ready_i  in  1  consumer accepts beat.
- wr_share_o  out  ShareIdxW  share index of beat.
- wr_idx_o  out  RegIdxW  word index of beat.
- wr_data_o  out  32  word data.
- wr_wipe_o  out  1  beat is a wipe (data is zero).
- key_valid_o  out  1  consumer holds the complete current key.
- busy_o  out  1  load or wipe in progress.
- err_o  out  1  sticky: key bits changed while valid held high.

Behaviour:
- Reset values: every output 0; FSM = IDLE; capture register 0; counters 0; err_o 0.
- FSM states: IDLE, LOAD, ACTIVE, WIPE.
- Word mapping: beat (s,i) carries key[s][i*32 +: 32].
  - Order: s=0, i=0..NumRegsKey-1, then s=1, i=0..NumRegsKey-1.
  - 16 beats at default parameters.
- Handshake:
  - A beat transfers on a cycle where wr_valid_o && wr_ready_i.
  - Once wr_valid_o is high, wr_valid_o, wr_share_o, wr_idx_o, wr_data_o and wr_wipe_o stay stable until the transfer.
  - wr_valid_o never retracts without a transfer.
  - wr_data_o = 0 whenever wr_valid_o = 0.
- IDLE:
  - If keymgr_key_i.valid = 1 at a clock edge: capture the key into the register, reset counters, go to LOAD.
  - wr_valid_o goes high in the first LOAD cycle, i.e. 1 cycle after valid is sampled.
- LOAD:
  - wr_valid_o = 1, wr_wipe_o = 0, busy_o = 1.
  - On each transfer the counter advances: i wraps from NumRegsKey-1 to 0 and s increments.
  - On the transfer of the final beat (s=NumSharesKey-1, i=NumRegsKey-1) go to ACTIVE.
  - key_valid_o = 1 from the next cycle.
  - With wr_ready_i tied high, key_valid_o rises 17 cycles after valid is sampled (defaults).
- valid drops during LOAD:
  - Set an abort flag.
  - The pending beat completes normally.
  - After that transfer, clear the capture register, reset counters and go to WIPE.
  - key_valid_o never asserts.
- ACTIVE:
  - wr_valid_o = 0, busy_o = 0, key_valid_o = 1.
  - If keymgr_key_i.valid = 0 at an edge: key_valid_o = 0 the next cycle, capture register cleared, counters reset, go to WIPE.
- WIPE:
  - Same beat sequence as LOAD, with wr_wipe_o = 1 and wr_data_o = 0 for every beat.
  - busy_o = 1, key_valid_o = 0.
  - After the final transfer go to IDLE.
  - All NumSharesKey*NumRegsKey words are always wiped, including after an abort.
- valid reasserts during WIPE: ignored until the wipe completes. IDLE samples it on the following edge and starts a fresh LOAD with the current key.
- Key change:
  - In LOAD or ACTIVE, if keymgr_key_i.valid = 1 and keymgr_key_i.key differs from the capture register, err_o sets the next cycle and stays set until reset.
  - No state change; the captured key is used.
- Reset asserted mid-LOAD or mid-WIPE: everything returns to reset values immediately (asynchronously). The consumer is responsible for its own reset clearing.
- Counter width rules: counters sized ShareIdxW/RegIdxW; the terminal compare uses parameter values and does not rely on natural overflow.

Decomposition:
- keymgr_pkg: hw_key_req_t (existing), KeyWidth=256, NumSharesKey=2, NumRegsKey=8, and the FSM state enum sideload_state_e.
- No sub-module: the counter, word mux and FSM fit in one module of ~200 lines.
- The word mux indexes the capture register as [share][idx*32 +: 32].

Test Plan:
- Basic load: rst_ni released; valid=1 with key[0]=256'h00..0F_0E.._00 pattern and key[1]=~key[0]; wr_ready_i=1.
  - Response: 16 beats in order (0,0)..(1,7); beat (0,1) data = key[0][63:32]; key_valid_o=1 exactly 17 cycles after valid sampled.
- Backpressure: wr_ready_i toggles 0/1 every cycle.
  - Response: outputs stable while ready=0; 16 transfers in 32 cycles; no beat skipped or repeated.
- Wipe: from ACTIVE, drop valid.
  - Response: key_valid_o=0 next cycle; 16 beats with wr_wipe_o=1 and data 0; then busy_o=0 and FSM in IDLE.
- Abort: drop valid after beat (0,4) while beat (0,5) is stalled with ready=0.
  - Response: beat (0,5) completes with key data; then a 16-beat wipe starts at (0,0); key_valid_o stays 0 throughout.
- Key change: in ACTIVE, flip key[1][0] while valid=1.
  - Response: err_o=1 the next cycle and stays 1; no beats issued; key_valid_o stays 1.
- Async reset mid-LOAD: assert rst_ni=0 at beat (1,2).
  - Response: wr_valid_o, busy_o and err_o are 0 with no clock edge; after release, valid=1 restarts from (0,0).

Source files
------------

// File: rtl/keymgr_pkg.sv
// Key manager types shared with sideload consumers: the hardware key request
// and the sideload sequencer state encoding.
package keymgr_pkg;

  localparam int unsigned KeyWidth     = 256;
  localparam int unsigned NumSharesKey = 2;
  localparam int unsigned NumRegsKey   = 8;
  localparam int unsigned WordW        = 32;
  localparam int unsigned ShareIdxW    = (NumSharesKey > 1) ? $clog2(NumSharesKey) : 1;
  localparam int unsigned RegIdxW      = (NumRegsKey > 1) ? $clog2(NumRegsKey) : 1;

  typedef logic [NumSharesKey-1:0][KeyWidth-1:0] key_shares_t;

  typedef struct packed {
    logic        valid;
    key_shares_t key;
  } hw_key_req_t;

  typedef enum logic [1:0] {
    SlIdle,
    SlLoad,
    SlActive,
    SlWipe
  } sideload_state_e;

  function automatic logic [WordW-1:0] key_word(input key_shares_t key,
                                                input logic [ShareIdxW-1:0] share,
                                                input logic [RegIdxW-1:0] idx);
    return key[share][idx*WordW +: WordW];
  endfunction

endpackage

// File: rtl/keymgr_sideload_ctrl.sv
// Streams a captured two-share key into a consumer's sideload registers one
// word per handshake, and wipes those registers when the key is withdrawn.
module keymgr_sideload_ctrl
  import keymgr_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  hw_key_req_t          keymgr_key_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [ShareIdxW-1:0] wr_share_o,
  output logic [RegIdxW-1:0]   wr_idx_o,
  output logic [WordW-1:0]     wr_data_o,
  output logic                 wr_wipe_o,
  output logic                 key_valid_o,
  output logic                 busy_o,
  output logic                 err_o
);

  sideload_state_e      state_q, state_d;
  key_shares_t          key_q, key_d;
  logic [ShareIdxW-1:0] share_q, share_d;
  logic [RegIdxW-1:0]   idx_q, idx_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 wr_wipe_q, wr_wipe_d;
  logic                 key_valid_q, key_valid_d;
  logic                 busy_q, busy_d;

  logic xfer;
  logic last_beat;
  logic key_changed;

  assign xfer        = wr_valid_q & wr_ready_i;
  assign last_beat   = (share_q == ShareIdxW'(NumSharesKey - 1)) &&
                       (idx_q == RegIdxW'(NumRegsKey - 1));
  assign key_changed = keymgr_key_i.valid && (keymgr_key_i.key != key_q);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    share_d     = share_q;
    idx_d       = idx_q;
    abort_d     = abort_q;
    err_d       = err_q;
    key_valid_d = 1'b0;

    unique case (state_q)
      SlIdle: begin
        if (keymgr_key_i.valid) begin
          key_d   = keymgr_key_i.key;
          share_d = '0;
          idx_d   = '0;
          abort_d = 1'b0;
          state_d = SlLoad;
        end
      end

      SlLoad: begin
        if (key_changed) err_d = 1'b1;
        // A withdrawn key still lets the presented beat finish before wiping.
        if (xfer) begin
          if (abort_q || !keymgr_key_i.valid) begin
            key_d   = '0;
            share_d = '0;
            idx_d   = '0;
            abort_d = 1'b0;
            state_d = SlWipe;
          end else if (last_beat) begin
            state_d = SlActive;
          end else if (idx_q == RegIdxW'(NumRegsKey - 1)) begin
            idx_d   = '0;
            share_d = share_q + ShareIdxW'(1);
          end else begin
            idx_d = idx_q + RegIdxW'(1);
          end
        end else if (!keymgr_key_i.valid) begin
          abort_d = 1'b1;
        end
      end

      SlActive: begin
        if (key_changed) err_d = 1'b1;
        if (!keymgr_key_i.valid) begin
          key_d   = '0;
          share_d = '0;
          idx_d   = '0;
          state_d = SlWipe;
        end else begin
          key_valid_d = 1'b1;
        end
      end

      SlWipe: begin
        if (xfer) begin
          if (last_beat) begin
            share_d = '0;
            idx_d   = '0;
            state_d = SlIdle;
          end else if (idx_q == RegIdxW'(NumRegsKey - 1)) begin
            idx_d   = '0;
            share_d = share_q + ShareIdxW'(1);
          end else begin
            idx_d = idx_q + RegIdxW'(1);
          end
        end
      end

      default: state_d = SlIdle;
    endcase

    wr_valid_d = (state_d == SlLoad) || (state_d == SlWipe);
    wr_wipe_d  = (state_d == SlWipe);
    busy_d     = wr_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SlIdle;
      key_q       <= '0;
      share_q     <= '0;
      idx_q       <= '0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_wipe_q   <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      share_q     <= share_d;
      idx_q       <= idx_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      wr_valid_q  <= wr_valid_d;
      wr_wipe_q   <= wr_wipe_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_valid_o  = wr_valid_q;
  assign wr_share_o  = share_q;
  assign wr_idx_o    = idx_q;
  assign wr_data_o   = (wr_valid_q && !wr_wipe_q) ? key_word(key_q, share_q, idx_q) : '0;
  assign wr_wipe_o   = wr_wipe_q;
  assign key_valid_o = key_valid_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule
